// File: rtl/map_top_and_bottom_pkg.sv
// Shared image constants, field widths and scanner state encoding for the
// top/bottom shape mapper.
package map_top_and_bottom_pkg;

  localparam int XSZ    = 6;
  localparam int YSZ    = 6;
  localparam int ADDRSZ = 12;
  localparam int COLSZ  = 3;

  localparam int               XRES_DEF      = 60;
  localparam int               YRES_DEF      = 60;
  localparam logic [COLSZ-1:0] THRESHOLD_DEF = '0;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_ADDR,
    SCAN_CHECK,
    COL_ADDR,
    COL_CHECK,
    FOUND,
    NONE
  } state_t;

endpackage

// File: rtl/map_top_and_bottom_address_translator.sv
// Converts an (x, y) pixel coordinate into a linear pixel-RAM address y*XRES + x.
module address_translator
  import map_top_and_bottom_pkg::*;
#(
  parameter int XRES = XRES_DEF
) (
  input  logic [XSZ-1:0]    x,
  input  logic [YSZ-1:0]    y,
  output logic [ADDRSZ-1:0] mem_address
);

  generate
    if (XRES == 60) begin : g_shift_add
      // y*60 = y*64 - y*4; the largest result (3599) fits in 12 bits.
      assign mem_address = {y, 6'b000000} - {4'b0000, y, 2'b00} + {6'b000000, x};
    end else begin : g_multiply
      assign mem_address = ADDRSZ'(ADDRSZ'(y) * ADDRSZ'(XRES)) + ADDRSZ'(x);
    end
  endgenerate

endmodule

// File: rtl/map_top_and_bottom.sv
// Finds the first non-background pixel in raster order, then follows its
// column downward to find the last contiguous non-background row.
module map_top_and_bottom
  import map_top_and_bottom_pkg::*;
#(
  parameter int               XRES      = XRES_DEF,
  parameter int               YRES      = YRES_DEF,
  parameter logic [COLSZ-1:0] THRESHOLD = THRESHOLD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDRSZ-1:0] address,
  input  logic [COLSZ-1:0]  pixVal,
  output logic              busy,
  output logic [YSZ-1:0]    mostTop,
  output logic [XSZ-1:0]    midPix,
  output logic [YSZ-1:0]    mostBottom,
  output logic              TopandBottomFound,
  output logic              noShape
);

  localparam logic [XSZ-1:0] X_LAST = XSZ'(XRES - 1);
  localparam logic [YSZ-1:0] Y_LAST = YSZ'(YRES - 1);
  localparam logic [XSZ-1:0] X_INC  = XSZ'(1);
  localparam logic [YSZ-1:0] Y_INC  = YSZ'(1);

  state_t         state_reg, state_next;
  logic [XSZ-1:0] x_reg, x_next;
  logic [YSZ-1:0] y_reg, y_next;
  logic [YSZ-1:0] top_reg, top_next;
  logic [XSZ-1:0] mid_reg, mid_next;
  logic [YSZ-1:0] bottom_reg, bottom_next;
  logic [YSZ-1:0] bottom_inc;
  logic [XSZ-1:0] addr_x;
  logic [YSZ-1:0] addr_y;
  logic           lit;

  assign bottom_inc = bottom_reg + Y_INC;
  assign lit        = (pixVal != THRESHOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      x_reg      <= '0;
      y_reg      <= '0;
      top_reg    <= '0;
      mid_reg    <= '0;
      bottom_reg <= '0;
    end else begin
      state_reg  <= state_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      top_reg    <= top_next;
      mid_reg    <= mid_next;
      bottom_reg <= bottom_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    top_next    = top_reg;
    mid_next    = mid_reg;
    bottom_next = bottom_reg;
    case (state_reg)
      IDLE: begin
        // Results are cleared only on an accepted start so they hold after FOUND.
        if (start) begin
          state_next  = SCAN_ADDR;
          x_next      = '0;
          y_next      = '0;
          top_next    = '0;
          mid_next    = '0;
          bottom_next = '0;
        end
      end
      SCAN_ADDR: state_next = SCAN_CHECK;
      SCAN_CHECK: begin
        if (lit) begin
          top_next    = y_reg;
          mid_next    = x_reg;
          bottom_next = y_reg;
          state_next  = (y_reg == Y_LAST) ? FOUND : COL_ADDR;
        end else if (x_reg != X_LAST) begin
          x_next     = x_reg + X_INC;
          state_next = SCAN_ADDR;
        end else if (y_reg != Y_LAST) begin
          x_next     = '0;
          y_next     = y_reg + Y_INC;
          state_next = SCAN_ADDR;
        end else begin
          state_next = NONE;
        end
      end
      COL_ADDR: state_next = COL_CHECK;
      COL_CHECK: begin
        if (lit) begin
          bottom_next = bottom_inc;
          state_next  = (bottom_inc == Y_LAST) ? FOUND : COL_ADDR;
        end else begin
          state_next = FOUND;
        end
      end
      FOUND:   state_next = IDLE;
      NONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Column reads never reach COL_ADDR with bottom at the last row, so
  // bottom+1 stays inside the image.
  assign addr_x = (state_reg == COL_ADDR) ? mid_reg    : x_reg;
  assign addr_y = (state_reg == COL_ADDR) ? bottom_inc : y_reg;

  address_translator #(
    .XRES(XRES)
  ) u_address_translator (
    .x          (addr_x),
    .y          (addr_y),
    .mem_address(address)
  );

  assign busy              = (state_reg != IDLE);
  assign TopandBottomFound = (state_reg == FOUND);
  assign noShape           = (state_reg == NONE);
  assign mostTop           = top_reg;
  assign midPix            = mid_reg;
  assign mostBottom        = bottom_reg;

endmodule
